// File: rtl/stack_cpu.sv
// Stack processor core: 8-bit opcodes from a synchronous code ROM, internal data and call stacks,
// and a single request/ready memory port. Stack errors and HALT park the core until reset.
module stack_cpu #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 12,
    parameter int DSTACK_DEPTH = 8,
    parameter int CSTACK_DEPTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] code_addr,
    input  logic [7:0]            code_data,
    output logic                  mem_req,
    output logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    input  logic                  mem_ready,
    output logic                  halted,
    output logic                  fault,
    output logic [1:0]            fault_code
);

    localparam int DIW = $clog2(DSTACK_DEPTH);
    localparam int DCW = $clog2(DSTACK_DEPTH + 1);
    localparam int CIW = $clog2(CSTACK_DEPTH);
    localparam int CCW = $clog2(CSTACK_DEPTH + 1);
    localparam logic [DCW-1:0] D_FULL = DCW'(DSTACK_DEPTH);
    localparam logic [CCW-1:0] C_FULL = CCW'(CSTACK_DEPTH);

    typedef enum logic [2:0] {FETCH, EXEC, MEM, HALT, FAULT} state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] dstack [DSTACK_DEPTH];
    logic [DCW-1:0]        d_count;
    logic [ADDR_WIDTH-1:0] cstack [CSTACK_DEPTH];
    logic [CCW-1:0]        c_count;

    logic [DIW-1:0]        s0_idx, s1_idx, push_idx;
    logic [CIW-1:0]        c_top_idx, c_push_idx;
    logic [DATA_WIDTH-1:0] s0, s1, lit, alu_res;
    logic [ADDR_WIDTH-1:0] next_pc, branch_pc;
    logic [DCW-1:0]        need;
    logic                  grow, c_err, is_mem, is_halt;
    logic                  d_under, d_over, bad;
    logic [1:0]            fault_code_next;
    logic                  exec_ok, mem_done;

    assign code_addr  = pc;
    assign s0_idx     = DIW'(d_count - DCW'(1));
    assign s1_idx     = DIW'(d_count - DCW'(2));
    assign push_idx   = DIW'(d_count);
    assign c_top_idx  = CIW'(c_count - CCW'(1));
    assign c_push_idx = CIW'(c_count);
    assign s0         = dstack[s0_idx];
    assign s1         = dstack[s1_idx];
    assign lit        = {{(DATA_WIDTH-7){code_data[6]}}, code_data[6:0]};
    assign next_pc    = pc + ADDR_WIDTH'(1);
    assign branch_pc  = next_pc + ADDR_WIDTH'(s0);

    // Decode: how many entries the opcode consumes, whether it grows the stack, and its class.
    always_comb begin
        need    = '0;
        grow    = 1'b0;
        c_err   = 1'b0;
        is_mem  = 1'b0;
        is_halt = 1'b0;
        if (code_data[7]) begin
            grow = 1'b1;
        end else begin
            case (code_data)
                8'h01: begin need = DCW'(1); is_mem = 1'b1; end
                8'h10: begin need = DCW'(2); is_mem = 1'b1; end
                8'h20, 8'h21, 8'h22, 8'h23, 8'h24: need = DCW'(2);
                8'h25, 8'h26, 8'h27, 8'h28:        need = DCW'(1);
                8'h30:        need = DCW'(1);
                8'h31, 8'h32: need = DCW'(2);
                8'h33: begin need = DCW'(1); c_err = (c_count == C_FULL); end
                8'h34: c_err = (c_count == '0);
                8'h42: begin need = DCW'(1); grow = 1'b1; end
                8'h43: need = DCW'(1);
                8'h44: is_halt = 1'b1;
                default: ;
            endcase
        end
        d_under = (d_count < need);
        d_over  = grow && (d_count == D_FULL);
        bad     = d_under || d_over || c_err;
        if (d_under)     fault_code_next = 2'b10;
        else if (d_over) fault_code_next = 2'b01;
        else             fault_code_next = 2'b11;
    end

    always_comb begin
        case (code_data)
            8'h20:   alu_res = s1 + s0;
            8'h21:   alu_res = s1 - s0;
            8'h22:   alu_res = s1 & s0;
            8'h23:   alu_res = s1 | s0;
            8'h24:   alu_res = s1 ^ s0;
            8'h25:   alu_res = s0 << 1;
            8'h26:   alu_res = s0 >> 1;
            8'h27:   alu_res = DATA_WIDTH'($signed(s0) >>> 1);
            8'h28:   alu_res = s0 << 6;
            default: alu_res = s0;
        endcase
    end

    always_comb begin
        state_next = state;
        exec_ok    = 1'b0;
        mem_done   = 1'b0;
        case (state)
            FETCH: state_next = EXEC;
            EXEC: begin
                if (bad)          state_next = FAULT;
                else if (is_halt) state_next = HALT;
                else if (is_mem)  state_next = MEM;
                else begin
                    state_next = FETCH;
                    exec_ok    = 1'b1;
                end
            end
            MEM: begin
                if (mem_ready) begin
                    state_next = FETCH;
                    mem_done   = 1'b1;
                end
            end
            HALT:    state_next = HALT;
            FAULT:   state_next = FAULT;
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    // Stack storage carries no reset; occupancy counters define which entries are live.
    always_ff @(posedge clock) begin
        if (exec_ok) begin
            if (code_data[7]) begin
                dstack[push_idx] <= lit;
            end else begin
                case (code_data)
                    8'h20, 8'h21, 8'h22, 8'h23, 8'h24: dstack[s1_idx] <= alu_res;
                    8'h25, 8'h26, 8'h27, 8'h28:        dstack[s0_idx] <= alu_res;
                    8'h42:   dstack[push_idx]   <= s0;
                    8'h33:   cstack[c_push_idx] <= next_pc;
                    default: ;
                endcase
            end
        end
        if (mem_done && !mem_write) dstack[s0_idx] <= mem_rd_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc          <= '0;
            d_count     <= '0;
            c_count     <= '0;
            mem_req     <= 1'b0;
            mem_write   <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            halted      <= 1'b0;
            fault       <= 1'b0;
            fault_code  <= 2'b00;
        end else begin
            if (state == EXEC) begin
                if (bad) begin
                    fault      <= 1'b1;
                    fault_code <= fault_code_next;
                end else if (is_halt) begin
                    halted <= 1'b1;
                end else if (is_mem) begin
                    mem_req     <= 1'b1;
                    mem_write   <= (code_data == 8'h10);
                    mem_addr    <= s0;
                    mem_wr_data <= s1;
                end
            end
            if (exec_ok) begin
                pc <= next_pc;
                if (code_data[7]) begin
                    d_count <= d_count + DCW'(1);
                end else begin
                    case (code_data)
                        8'h20, 8'h21, 8'h22, 8'h23, 8'h24: d_count <= d_count - DCW'(1);
                        8'h30: begin
                            pc      <= branch_pc;
                            d_count <= d_count - DCW'(1);
                        end
                        8'h31: begin
                            if (s1 == '0) pc <= branch_pc;
                            d_count <= d_count - DCW'(2);
                        end
                        8'h32: begin
                            if (s1 != '0) pc <= branch_pc;
                            d_count <= d_count - DCW'(2);
                        end
                        8'h33: begin
                            pc      <= branch_pc;
                            d_count <= d_count - DCW'(1);
                            c_count <= c_count + CCW'(1);
                        end
                        8'h34: begin
                            pc      <= cstack[c_top_idx];
                            c_count <= c_count - CCW'(1);
                        end
                        8'h42:   d_count <= d_count + DCW'(1);
                        8'h43:   d_count <= d_count - DCW'(1);
                        default: ;
                    endcase
                end
            end
            if (mem_done) begin
                mem_req   <= 1'b0;
                mem_write <= 1'b0;
                pc        <= next_pc;
                if (mem_write) d_count <= d_count - DCW'(2);
            end
        end
    end

endmodule

// File: tb/tb_stack_cpu.sv
// Directed bench for stack_cpu: small ROM programs with hand-computed results, a ROM model
// with one-cycle latency, and a memory port answered from the stimulus sequence.
module tb_stack_cpu;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] code_addr;
    logic [7:0]  code_data = 8'h00;
    logic        mem_req, mem_write;
    logic [15:0] mem_addr, mem_wr_data;
    logic [15:0] mem_rd_data = 16'h0000;
    logic        mem_ready = 1'b0;
    logic        halted, fault;
    logic [1:0]  fault_code;

    logic [7:0]  rom [4096];
    int          compared = 0;
    int          mismatched = 0;
    int          cycles;
    int          held;

    stack_cpu dut (
        .clock(clock), .reset(reset),
        .code_addr(code_addr), .code_data(code_data),
        .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .mem_ready(mem_ready),
        .halted(halted), .fault(fault), .fault_code(fault_code)
    );

    always #5 clock = ~clock;

    always @(posedge clock) code_data <= rom[code_addr];

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Program bytes are given first-opcode-leftmost in p; n is the byte count.
    task automatic apply_stimulus(input logic [95:0] p, input int n);
        reset       = 1'b1;
        mem_ready   = 1'b0;
        mem_rd_data = 16'h0000;
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
        for (int i = 0; i < n; i++) rom[i] = p[8*(n-1-i) +: 8];
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic run_until_done(input int budget, output int count);
        count = 0;
        while (!halted && !fault && count < budget) begin
            @(negedge clock);
            count++;
        end
    endtask

    task automatic wait_req(input int budget);
        int n = 0;
        while (!mem_req && n < budget) begin
            @(negedge clock);
            n++;
        end
        check_output("mem_req_seen", {31'd0, mem_req}, 32'd1);
    endtask

    // Called at a negedge with mem_req high; mem_ready rises for the waits-th MEM cycle.
    task automatic serve_mem(input int waits, input logic [15:0] rd, output int held_cycles);
        held_cycles = 0;
        for (int i = 0; i < waits; i++) begin
            if (mem_req) held_cycles++;
            if (i == waits - 1) begin
                mem_ready   = 1'b1;
                mem_rd_data = rd;
            end
            @(negedge clock);
        end
        mem_ready = 1'b0;
    endtask

    initial begin
        // push 3, push 4, ADD, HALT
        apply_stimulus(96'h83_84_20_44, 4);
        reset = 1'b1;
        #1;
        check_output("rst_code_addr", {20'd0, code_addr}, 32'h0);
        check_output("rst_mem_req", {31'd0, mem_req}, 32'h0);
        check_output("rst_mem_write", {31'd0, mem_write}, 32'h0);
        check_output("rst_mem_addr", {16'd0, mem_addr}, 32'h0);
        check_output("rst_mem_wr_data", {16'd0, mem_wr_data}, 32'h0);
        check_output("rst_halted", {31'd0, halted}, 32'h0);
        check_output("rst_fault", {31'd0, fault}, 32'h0);
        check_output("rst_fault_code", {30'd0, fault_code}, 32'h0);
        check_output("rst_dcount", 32'(dut.d_count), 32'h0);
        check_output("rst_ccount", 32'(dut.c_count), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 7; i++) @(negedge clock);
        check_output("add_halt_not_yet", {31'd0, halted}, 32'h0);
        @(negedge clock);
        check_output("add_halted_at_8", {31'd0, halted}, 32'h1);
        check_output("add_s0", 32'(dut.s0), 32'h7);
        check_output("add_dcount", 32'(dut.d_count), 32'h1);
        check_output("add_fault", {31'd0, fault}, 32'h0);

        // push 5, push 0x20, STORE, push 0x20, LOAD, HALT
        apply_stimulus(96'h85_A0_10_A0_01_44, 6);
        wait_req(20);
        check_output("st_write", {31'd0, mem_write}, 32'h1);
        check_output("st_addr", {16'd0, mem_addr}, 32'h20);
        check_output("st_data", {16'd0, mem_wr_data}, 32'h5);
        serve_mem(3, 16'h0000, held);
        check_output("st_held", held, 32'd3);
        check_output("st_req_drop", {31'd0, mem_req}, 32'h0);
        check_output("st_dcount", 32'(dut.d_count), 32'h0);
        wait_req(20);
        check_output("ld_write", {31'd0, mem_write}, 32'h0);
        check_output("ld_addr", {16'd0, mem_addr}, 32'h20);
        serve_mem(1, 16'h0005, held);
        run_until_done(20, cycles);
        check_output("ld_halted", {31'd0, halted}, 32'h1);
        check_output("ld_s0", 32'(dut.s0), 32'h5);
        check_output("ld_dcount", 32'(dut.d_count), 32'h1);

        // reset while a store is waiting for mem_ready
        apply_stimulus(96'h85_A0_10_44, 4);
        wait_req(20);
        #2 reset = 1'b1;
        #1;
        check_output("async_rst_req", {31'd0, mem_req}, 32'h0);
        check_output("async_rst_pc", 32'(dut.pc), 32'h0);

        // push 2, CALL(+2 -> 4), [2] HALT, [3] NOP, [4] push 1, [5] RET
        apply_stimulus(96'h82_33_44_00_81_34, 6);
        run_until_done(40, cycles);
        check_output("call_cycles", cycles, 32'd10);
        check_output("call_halted", {31'd0, halted}, 32'h1);
        check_output("call_pc", 32'(dut.pc), 32'h2);
        check_output("call_s0", 32'(dut.s0), 32'h1);
        check_output("call_dcount", 32'(dut.d_count), 32'h1);
        check_output("call_ccount", 32'(dut.c_count), 32'h0);

        // JZ taken skips two NOPs; fall-through executes them
        apply_stimulus(96'h80_82_31_00_00_44, 6);
        run_until_done(40, cycles);
        check_output("jz_taken_cycles", cycles, 32'd8);
        check_output("jz_taken_dcount", 32'(dut.d_count), 32'h0);
        check_output("jz_taken_pc", 32'(dut.pc), 32'h5);
        apply_stimulus(96'h81_82_31_00_00_44, 6);
        run_until_done(40, cycles);
        check_output("jz_fall_cycles", cycles, 32'd12);
        check_output("jz_fall_dcount", 32'(dut.d_count), 32'h0);
        apply_stimulus(96'h81_82_32_00_00_44, 6);
        run_until_done(40, cycles);
        check_output("jnz_taken_cycles", cycles, 32'd8);

        // nine pushes into an eight-entry stack
        apply_stimulus(96'h81_82_83_84_85_86_87_88_89, 9);
        run_until_done(60, cycles);
        check_output("ovf_cycles", cycles, 32'd18);
        check_output("ovf_fault", {31'd0, fault}, 32'h1);
        check_output("ovf_code", {30'd0, fault_code}, 32'h1);
        check_output("ovf_dcount", 32'(dut.d_count), 32'h8);
        check_output("ovf_s0", 32'(dut.s0), 32'h8);
        check_output("ovf_halted", {31'd0, halted}, 32'h0);

        apply_stimulus(96'h20, 1);
        run_until_done(20, cycles);
        check_output("unf_cycles", cycles, 32'd2);
        check_output("unf_code", {30'd0, fault_code}, 32'h2);
        check_output("unf_dcount", 32'(dut.d_count), 32'h0);

        apply_stimulus(96'h34, 1);
        run_until_done(20, cycles);
        check_output("ret_empty_code", {30'd0, fault_code}, 32'h3);

        // build 0x7F (63+63+1) then SHL6
        apply_stimulus(96'hBF_42_20_81_20_28_44, 7);
        run_until_done(40, cycles);
        check_output("shl6_s0", 32'(dut.s0), 32'h1FC0);
        apply_stimulus(96'hFF_26_44, 3);
        run_until_done(20, cycles);
        check_output("lsr1_s0", 32'(dut.s0), 32'h7FFF);
        apply_stimulus(96'hFF_27_44, 3);
        run_until_done(20, cycles);
        check_output("asr1_s0", 32'(dut.s0), 32'hFFFF);
        // 5 - 3 = 2, SHL1 -> 4, XOR 6 -> 2, OR 8 -> 0xA, AND 3 -> 2
        apply_stimulus(96'h85_83_21_25_86_24_88_23_83_22_44, 11);
        run_until_done(60, cycles);
        check_output("alu_mix_s0", 32'(dut.s0), 32'h2);
        check_output("alu_mix_dcount", 32'(dut.d_count), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/stack_cpu.md
# stack_cpu

Parametrised next-generation stack processor core: fetches 8-bit opcodes from a one-cycle-latency synchronous code ROM, executes them against internal data and call stacks of configurable depth, and reaches RAM/IO through a single request/ready memory port that tolerates wait states. It adds working call/return, shift operations, stack overflow/underflow fault detection, and a halt state. It sits between the code ROM and the system address decoder.

## Interface

- DATA_WIDTH, 16: data-stack and memory word width (≥ 8)
- ADDR_WIDTH, 12: code address width
- DSTACK_DEPTH, 8: data-stack entries (power of two, ≥ 4)
- CSTACK_DEPTH, 8: call-stack entries (power of two, ≥ 2)
- clock  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- code_addr  out  ADDR_WIDTH  ROM address; code_data valid the cycle after
- code_data  in  8  opcode from ROM
- mem_req  out  1  memory request, held until mem_ready
- mem_write  out  1  1 = store, 0 = load; valid with mem_req
- mem_addr  out  DATA_WIDTH  memory address (S0)
- mem_wr_data  out  DATA_WIDTH  store data (S1)
- mem_rd_data  in  DATA_WIDTH  load data, valid when mem_ready
- mem_ready  in  1  completes current request
- halted  out  1  HALT executed
- fault  out  1  stack error; fault_code valid
- fault_code  out  2  01 data overflow, 10 data underflow, 11 call-stack over/underflow

## Operation

- S0 = top of data stack, S1 = next. Stacks are register arrays with occupancy counters (0..DEPTH).
- Opcodes (all others are NOPs):
  - 1xxxxxxx: push sign-extended 7-bit literal.
  - 0x01 LOAD: S0 ← mem[S0]. 0x10 STORE: mem[S0] ← S1, pop 2.
  - 0x20 ADD, 0x21 SUB (S1−S0), 0x22 AND, 0x23 OR, 0x24 XOR: result replaces S1, pop 1. 0x25 SHL1, 0x26 LSR1, 0x27 ASR1, 0x28 SHL6: in place on S0. Results truncated to DATA_WIDTH.
  - 0x30 JMP: pop S0, pc ← next + S0. 0x31 JZ / 0x32 JNZ: test S1, pop 2, branch to next + S0 if taken. 0x33 CALL: push next to call stack, pop S0, pc ← next + S0. 0x34 RET: pc ← popped call-stack entry.
  - 0x42 DUP, 0x43 DROP, 0x44 HALT.
- next = opcode address + 1; branch target uses S0[ADDR_WIDTH-1:0], wraps mod 2^ADDR_WIDTH. pc also wraps at 2^ADDR_WIDTH−1.
- Required occupancy is checked before execution: pops exceeding occupancy → underflow; push at DEPTH → overflow; CALL with full or RET with empty call stack → code 11. A faulting instruction modifies no state.
- States: FETCH, EXEC, MEM, HALT, FAULT.
  - FETCH: code_addr = pc → EXEC.
  - EXEC: decode code_data. LOAD/STORE → MEM; HALT → HALT; fault → FAULT; else commit, → FETCH.
  - MEM: mem_req = 1 until mem_ready; then commit, → FETCH.
  - HALT, FAULT: terminal until reset; no requests.

## Timing

- Reset values: pc 0, both occupancies 0, state FETCH, code_addr 0, mem_req 0, mem_write 0, mem_addr 0, mem_wr_data 0, halted 0, fault 0, fault_code 00.
- Non-memory instruction: 2 cycles. LOAD/STORE: 2 + W cycles, where W ≥ 1 counts MEM cycles up to and including the one with mem_ready high.
- mem_req, mem_write, mem_addr and mem_wr_data are registered and stable from the first MEM cycle until mem_ready. Only one request is outstanding at a time. mem_ready outside MEM is ignored.
- halted and fault are registered; each asserts the cycle after the HALT or faulting opcode is decoded.
- Asynchronous reset mid-request: mem_req drops immediately; the pending access is abandoned.

## Test plan

- Push 3, push 4, ADD, HALT → S0 = 7, occupancy 1, halted after 8 cycles.
- Push 5, push 0x20 address, STORE with mem_ready delayed 3 cycles → mem_req held 3 cycles, mem_addr 0x20, mem_wr_data 5. Then LOAD 0x20 → S0 = 5.
- CALL to a subroutine containing push 1, RET → execution resumes at the opcode after CALL; call occupancy returns to 0.
- Push 0, push +2, JZ → skips 2 opcodes. Same with condition 1 → falls through. Occupancy 0 in both cases.
- DSTACK_DEPTH + 1 pushes → fault, fault_code 01, stack unchanged. ADD on an empty stack → fault_code 10.
- Push 0x7F, SHL6 with DATA_WIDTH = 16 → S0 = 0x1FC0. Push −1, LSR1 → 0x7FFF; ASR1 → 0xFFFF.
